// File: rtl/uart_tx_arbiter_if.sv
// Bus between the byte producers, the arbiter and the UART transmitter.
//   req/data : per-source request level and byte slice (data[i*DWL +: DWL] pairs with req[i])
//   ack      : one-hot capture pulse back to the sources
//   tx_we/tx_data/tx_busy : UART_Tx write strobe, parallel byte and busy flag
//   gnt_id/active/err     : last granted source, arbiter not idle, start timeout pulse
interface uart_tx_arbiter_if #(
    parameter int unsigned DWL = 8,
    parameter int unsigned N   = 4
);
    localparam int unsigned IW = $clog2(N);

    logic [N-1:0]     req;
    logic [N*DWL-1:0] data;
    logic [N-1:0]     ack;
    logic             tx_we;
    logic [DWL-1:0]   tx_data;
    logic             tx_busy;
    logic [IW-1:0]    gnt_id;
    logic             active;
    logic             err;

    // Environment side: producers plus the UART busy flag.
    modport master (
        output req, data, tx_busy,
        input  ack, tx_we, tx_data, gnt_id, active, err
    );

    // Arbiter side.
    modport slave (
        input  req, data, tx_busy,
        output ack, tx_we, tx_data, gnt_id, active, err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N byte sources.
// Grants one requester, captures its byte, holds tx_we until tx_busy confirms
// capture, waits for the frame to end plus GAP idle cycles, then re-arbitrates.
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : uart_tx_arbiter_if.slave (requests, bytes, acks, UART write side, status)
module uart_tx_arbiter #(
    parameter int unsigned DWL           = 8,
    parameter int unsigned N             = 4,
    parameter int unsigned GAP           = 0,
    parameter int unsigned START_TIMEOUT = 16384
) (
    input  logic              clk,
    input  logic              rst,
    uart_tx_arbiter_if.slave  bus
);
    localparam int unsigned IW      = $clog2(N);
    localparam int unsigned CNT_MAX = (START_TIMEOUT > GAP) ? START_TIMEOUT : GAP;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DONE,
        S_GAP
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [IW-1:0]  ptr_q, ptr_d;
    logic [IW-1:0]  gnt_id_q, gnt_id_d;
    logic [DWL-1:0] tx_data_q, tx_data_d;
    logic           tx_we_q, tx_we_d;
    logic [N-1:0]   ack_q, ack_d;
    logic           err_q, err_d;
    logic           active_q, active_d;

    logic           win_found;
    logic [IW-1:0]  win_idx;
    logic [IW-1:0]  cand;
    logic [DWL-1:0] win_data;

    // Round-robin search starting just after the last winner.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = IW'((32'(ptr_q) + k) % N);
            if (!win_found && bus.req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Byte slice of the winning source.
    always_comb begin
        win_data = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (win_idx == IW'(k)) begin
                win_data = bus.data[k*DWL +: DWL];
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        gnt_id_d  = gnt_id_q;
        tx_data_d = tx_data_q;
        tx_we_d   = tx_we_q;
        ack_d     = '0;
        err_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                // A busy UART here is a foreign or leftover frame: hold off.
                if (win_found && !bus.tx_busy) begin
                    tx_data_d      = win_data;
                    gnt_id_d       = win_idx;
                    ptr_d          = win_idx;
                    ack_d[win_idx] = 1'b1;
                    tx_we_d        = 1'b1;
                    cnt_d          = '0;
                    state_d        = S_START;
                end
            end
            S_START: begin
                if (bus.tx_busy) begin
                    tx_we_d = 1'b0;
                    state_d = S_DONE;
                end else if (cnt_q == CW'(START_TIMEOUT - 1)) begin
                    // Byte is dropped; the source was already acknowledged.
                    tx_we_d = 1'b0;
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                if (!bus.tx_busy) begin
                    if (GAP == 0) begin
                        state_d = S_IDLE;
                    end else begin
                        cnt_d   = CW'(GAP - 1);
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        active_d = (state_d != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            ptr_q     <= IW'(N - 1);
            gnt_id_q  <= '0;
            tx_data_q <= '0;
            tx_we_q   <= 1'b0;
            ack_q     <= '0;
            err_q     <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            gnt_id_q  <= gnt_id_d;
            tx_data_q <= tx_data_d;
            tx_we_q   <= tx_we_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            active_q  <= active_d;
        end
    end

    assign bus.ack     = ack_q;
    assign bus.tx_we   = tx_we_q;
    assign bus.tx_data = tx_data_q;
    assign bus.gnt_id  = gnt_id_q;
    assign bus.active  = active_q;
    assign bus.err     = err_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: two instances (GAP=0/timeout 8 and
// GAP=5/timeout 64), each with a small behavioural UART busy model.
module tb_uart_tx_arbiter;
    localparam int unsigned DWL   = 8;
    localparam int unsigned N     = 4;
    localparam int unsigned GAP_A = 0;
    localparam int unsigned GAP_B = 5;
    localparam int unsigned TO_A  = 8;
    localparam int unsigned TO_B  = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    logic [N-1:0]     req_d  [2];
    logic [N*DWL-1:0] data_d [2];
    logic [N-1:0]     ack_s  [2];
    logic             we_s   [2];
    logic [DWL-1:0]   txd_s  [2];
    logic [1:0]       gid_s  [2];
    logic             act_s  [2];
    logic             err_s  [2];
    logic             busy_s [2];

    // UART busy model controls: auto mode raises busy bdelay cycles after tx_we,
    // holds it bframe cycles; manual mode drives bman.
    bit   bauto  [2];
    logic bman   [2];
    int   bdelay [2];
    int   bframe [2];
    int   bst    [2];
    int   bcnt   [2];

    uart_tx_arbiter_if #(.DWL(DWL), .N(N)) if_a ();
    uart_tx_arbiter_if #(.DWL(DWL), .N(N)) if_b ();

    assign if_a.req = req_d[0];
    assign if_a.data = data_d[0];
    assign if_a.tx_busy = busy_s[0];
    assign if_b.req = req_d[1];
    assign if_b.data = data_d[1];
    assign if_b.tx_busy = busy_s[1];

    assign ack_s[0] = if_a.ack;     assign ack_s[1] = if_b.ack;
    assign we_s[0]  = if_a.tx_we;   assign we_s[1]  = if_b.tx_we;
    assign txd_s[0] = if_a.tx_data; assign txd_s[1] = if_b.tx_data;
    assign gid_s[0] = if_a.gnt_id;  assign gid_s[1] = if_b.gnt_id;
    assign act_s[0] = if_a.active;  assign act_s[1] = if_b.active;
    assign err_s[0] = if_a.err;     assign err_s[1] = if_b.err;

    assign busy_s[0] = bauto[0] ? (bst[0] == 2) : bman[0];
    assign busy_s[1] = bauto[1] ? (bst[1] == 2) : bman[1];

    uart_tx_arbiter #(.DWL(DWL), .N(N), .GAP(GAP_A), .START_TIMEOUT(TO_A)) dut_a (
        .clk(clk), .rst(rst), .bus(if_a)
    );
    uart_tx_arbiter #(.DWL(DWL), .N(N), .GAP(GAP_B), .START_TIMEOUT(TO_B)) dut_b (
        .clk(clk), .rst(rst), .bus(if_b)
    );

    // UART busy model, evaluated just after each rising edge.
    always @(posedge clk) begin
        #1;
        for (int k = 0; k < 2; k++) begin
            if (rst || !bauto[k]) begin
                bst[k] = 0;
            end else begin
                case (bst[k])
                    0: if (we_s[k]) begin
                        if (bdelay[k] == 0) begin bst[k] = 2; bcnt[k] = bframe[k]; end
                        else begin bst[k] = 1; bcnt[k] = bdelay[k]; end
                    end
                    1: begin
                        bcnt[k] = bcnt[k] - 1;
                        if (bcnt[k] == 0) begin bst[k] = 2; bcnt[k] = bframe[k]; end
                    end
                    default: begin
                        bcnt[k] = bcnt[k] - 1;
                        if (bcnt[k] == 0) bst[k] = 0;
                    end
                endcase
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            req_d[k] = '0; data_d[k] = '0;
            bauto[k] = 1'b1; bman[k] = 1'b0; bdelay[k] = 0; bframe[k] = 3;
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_ack(input int k, input int bound, output int lat);
        lat = 0;
        while (ack_s[k] == '0 && lat < bound) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic wait_idle(input string nm, input int k, input int bound);
        int n;
        n = 0;
        while (act_s[k] && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk(nm, 32'(act_s[k]), 0);
    endtask

    // Reference round-robin: first requester after the last winner.
    function automatic int rr(input logic [N-1:0] r, input int p);
        for (int s = 1; s <= N; s++) begin
            if (r[(p + s) % N]) return (p + s) % N;
        end
        return -1;
    endfunction

    typedef struct {
        logic [N-1:0] req;
        logic [31:0]  data;
        logic [N-1:0] exp_ack;
        logic [1:0]   exp_id;
        logic [7:0]   exp_byte;
    } vec_t;

    vec_t vt[10];
    logic [N-1:0] rr_ord[5];

    initial begin
        int lat, n, tprev, tfall;
        int ptr_m[2], ready_c[2];
        bit in_xfer[2], seen_busy[2];
        logic [N-1:0] prev_req[2];
        logic [31:0] prev_data[2];
        logic [N-1:0] eo;
        int w;

        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            req_d[k] = '0; data_d[k] = '0; bauto[k] = 1'b1; bman[k] = 1'b0;
            bdelay[k] = 0; bframe[k] = 3; bst[k] = 0; bcnt[k] = 0;
        end

        vt[0] = '{4'b0001, 32'h112233A5, 4'b0001, 2'd0, 8'hA5};
        vt[1] = '{4'b1111, 32'h44332211, 4'b0010, 2'd1, 8'h22};
        vt[2] = '{4'b1111, 32'h88776655, 4'b0100, 2'd2, 8'h77};
        vt[3] = '{4'b1111, 32'hCCBBAA99, 4'b1000, 2'd3, 8'hCC};
        vt[4] = '{4'b1111, 32'h0F0E0DF0, 4'b0001, 2'd0, 8'hF0};
        vt[5] = '{4'b1010, 32'h13579BDF, 4'b0010, 2'd1, 8'h9B};
        vt[6] = '{4'b1010, 32'h2468ACE0, 4'b1000, 2'd3, 8'h24};
        vt[7] = '{4'b0100, 32'h5AC33CA5, 4'b0100, 2'd2, 8'hC3};
        vt[8] = '{4'b1001, 32'hDEADBEEF, 4'b1000, 2'd3, 8'hDE};
        vt[9] = '{4'b0011, 32'h01020304, 4'b0001, 2'd0, 8'h04};
        rr_ord = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        // Reset values on both instances.
        do_reset();
        for (int k = 0; k < 2; k++) begin
            chk("rst_ack", 32'(ack_s[k]), 0);
            chk("rst_we", 32'(we_s[k]), 0);
            chk("rst_txdata", 32'(txd_s[k]), 0);
            chk("rst_gnt", 32'(gid_s[k]), 0);
            chk("rst_active", 32'(act_s[k]), 0);
            chk("rst_err", 32'(err_s[k]), 0);
        end

        // Table-driven single transfers on instance A.
        for (int i = 0; i < 10; i++) begin
            req_d[0] = vt[i].req;
            data_d[0] = vt[i].data;
            wait_ack(0, 40, lat);
            chk("vec_latency", 32'(lat), 1);
            chk("vec_ack", 32'(ack_s[0]), 32'(vt[i].exp_ack));
            chk("vec_gnt", 32'(gid_s[0]), 32'(vt[i].exp_id));
            chk("vec_txdata", 32'(txd_s[0]), 32'(vt[i].exp_byte));
            chk("vec_we", 32'(we_s[0]), 1);
            req_d[0] = '0;
            wait_idle("vec_idle", 0, 40);
        end

        // Busy rising 3 cycles after the grant: tx_we high 4 cycles, ack 1 cycle.
        do_reset();
        bdelay[0] = 3; bframe[0] = 4;
        req_d[0] = 4'b0001; data_d[0] = 32'h000000A5;
        wait_ack(0, 40, lat);
        chk("t1_ack", 32'(ack_s[0]), 32'h1);
        chk("t1_txdata", 32'(txd_s[0]), 32'hA5);
        chk("t1_gnt", 32'(gid_s[0]), 0);
        req_d[0] = '0;
        n = 0;
        while (we_s[0] && n < 40) begin
            @(negedge clk);
            n++;
            if (n == 1) chk("t1_ack_pulse", 32'(ack_s[0]), 0);
        end
        chk("t1_we_cycles", 32'(n), 4);
        wait_idle("t1_idle", 0, 40);

        // All four requesting, 10-cycle frames: fair order and 12-cycle spacing.
        do_reset();
        bdelay[0] = 0; bframe[0] = 10;
        req_d[0] = 4'b1111; data_d[0] = 32'h55AA33CC;
        tprev = 0;
        for (int g = 0; g < 5; g++) begin
            wait_ack(0, 40, lat);
            chk("rr_order", 32'(ack_s[0]), 32'(rr_ord[g]));
            if (g > 0) chk("rr_spacing", 32'(cyc - tprev), 12);
            tprev = cyc;
            @(negedge clk);
        end
        req_d[0] = '0;
        wait_idle("rr_idle", 0, 40);

        // GAP=5 instance: busy fall to next grant is GAP+2 cycles.
        do_reset();
        bdelay[1] = 0; bframe[1] = 4;
        req_d[1] = 4'b0011; data_d[1] = 32'h0000BEEF;
        wait_ack(1, 40, lat);
        chk("gap_first_ack", 32'(ack_s[1]), 32'b0001);
        n = 0;
        while (!busy_s[1] && n < 40) begin @(negedge clk); n++; end
        n = 0;
        while (busy_s[1] && n < 40) begin @(negedge clk); n++; end
        tfall = cyc;
        wait_ack(1, 40, lat);
        chk("gap_spacing", 32'(cyc - tfall), GAP_B + 2);
        chk("gap_second_ack", 32'(ack_s[1]), 32'b0010);
        req_d[1] = '0;
        wait_idle("gap_idle", 1, 40);

        // Start timeout with busy stuck low.
        do_reset();
        bauto[0] = 1'b0; bman[0] = 1'b0;
        req_d[0] = 4'b0010; data_d[0] = 32'h00007700;
        wait_ack(0, 40, lat);
        chk("to_ack", 32'(ack_s[0]), 32'b0010);
        n = 0;
        while (we_s[0] && n < 30) begin n++; @(negedge clk); end
        chk("to_we_cycles", 32'(n), TO_A);
        chk("to_err", 32'(err_s[0]), 1);
        chk("to_active", 32'(act_s[0]), 0);
        @(negedge clk);
        chk("to_err_pulse", 32'(err_s[0]), 0);
        chk("to_regrant", 32'(ack_s[0]), 32'b0010);
        bauto[0] = 1'b1;
        req_d[0] = '0;
        wait_idle("to_idle", 0, 40);

        // Async reset in START, then in DONE.
        do_reset();
        bauto[0] = 1'b0; bman[0] = 1'b0;
        req_d[0] = 4'b0100; data_d[0] = 32'h00110000;
        wait_ack(0, 40, lat);
        chk("rs_ack", 32'(ack_s[0]), 32'b0100);
        req_d[0] = '0;
        #2 rst = 1'b1;
        #1;
        chk("rs_start_we", 32'(we_s[0]), 0);
        chk("rs_start_ack", 32'(ack_s[0]), 0);
        chk("rs_start_active", 32'(act_s[0]), 0);
        @(negedge clk);
        rst = 1'b0;
        req_d[0] = 4'b0100;
        wait_ack(0, 40, lat);
        bman[0] = 1'b1;
        req_d[0] = '0;
        @(negedge clk);
        chk("rd_in_done_we", 32'(we_s[0]), 0);
        chk("rd_in_done_active", 32'(act_s[0]), 1);
        #2 rst = 1'b1;
        #1;
        chk("rd_done_we", 32'(we_s[0]), 0);
        chk("rd_done_active", 32'(act_s[0]), 0);
        @(negedge clk);
        rst = 1'b0;
        bman[0] = 1'b0;
        @(negedge clk);
        chk("rd_no_err", 32'(err_s[0]), 0);
        chk("rd_no_ack", 32'(ack_s[0]), 0);
        bauto[0] = 1'b1;
        req_d[0] = 4'b1111;
        wait_ack(0, 40, lat);
        chk("rd_prio0", 32'(ack_s[0]), 32'b0001);
        req_d[0] = '0;
        wait_idle("rd_idle", 0, 40);

        // Foreign busy in IDLE blocks the grant until it clears.
        do_reset();
        bauto[0] = 1'b0; bman[0] = 1'b1;
        req_d[0] = 4'b0100; data_d[0] = 32'h00420000;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("fb_no_ack", 32'(ack_s[0]), 0);
            chk("fb_not_active", 32'(act_s[0]), 0);
        end
        bman[0] = 1'b0;
        @(negedge clk);
        chk("fb_grant", 32'(ack_s[0]), 32'b0100);
        chk("fb_txdata", 32'(txd_s[0]), 32'h42);
        bauto[0] = 1'b1;
        req_d[0] = '0;
        wait_idle("fb_idle", 0, 40);

        // Random requests on both instances against a cycle-level reference.
        do_reset();
        for (int k = 0; k < 2; k++) begin
            ptr_m[k] = N - 1; ready_c[k] = 0; in_xfer[k] = 0; seen_busy[k] = 0;
            prev_req[k] = '0; prev_data[k] = '0;
        end
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (!in_xfer[k] && cyc >= ready_c[k] && prev_req[k] != '0) begin
                    w = rr(prev_req[k], ptr_m[k]);
                    eo = '0;
                    eo[w] = 1'b1;
                    chk("rnd_ack", 32'(ack_s[k]), 32'(eo));
                    chk("rnd_gnt", 32'(gid_s[k]), 32'(w));
                    chk("rnd_txdata", 32'(txd_s[k]), 32'(prev_data[k][w*8 +: 8]));
                    chk("rnd_we", 32'(we_s[k]), 1);
                    ptr_m[k] = w;
                    in_xfer[k] = 1;
                    seen_busy[k] = 0;
                end else begin
                    chk("rnd_no_ack", 32'(ack_s[k]), 0);
                end
                chk("rnd_err", 32'(err_s[k]), 0);
                if (in_xfer[k] && busy_s[k]) seen_busy[k] = 1;
                if (in_xfer[k] && seen_busy[k] && !busy_s[k]) begin
                    in_xfer[k] = 0;
                    ready_c[k] = cyc + ((k == 0) ? GAP_A : GAP_B) + 2;
                end
                if (!in_xfer[k]) begin
                    bdelay[k] = $urandom_range(0, 3);
                    bframe[k] = $urandom_range(1, 6);
                end
                prev_req[k] = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom_range(0, 15));
                prev_data[k] = $urandom;
                req_d[k] = prev_req[k];
                data_d[k] = prev_data[k];
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
